// File: rtl/sfu_iter.sv
// sfu_iter: iterative special-function unit (reciprocal / square root).
//
// Computes one result per transaction on an unsigned Q(WIDTH-FRAC).FRAC operand:
//   op 2'b00 RCP : floor(2^(2*FRAC) / in_data), saturating to all ones
//   op 2'b01 SQRT: floor(sqrt(in_data * 2^FRAC))
//   op 2'b1x     : illegal, returns 0 with flags[2]
// Every operation takes the same latency: out_valid rises on the
// (WIDTH+FRAC+1)th clock edge after the accepting edge. At most one
// transaction is in flight.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_op, in_data, in_tag request payload
//   out_valid/out_ready result handshake; out_data, out_tag, out_flags payload
//   out_flags           [0] divide by zero, [1] saturated, [2] illegal op
//   flush               (only with SFU_FLUSH_EN) synchronous abort of the
//                       in-flight transaction
//
// Build option: define SFU_FLUSH_EN to add the flush input.
module sfu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
`ifdef SFU_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int unsigned L     = WIDTH + FRAC;   // compute cycles
  localparam int unsigned DW    = L;              // dividend / quotient width
  localparam int unsigned SQ_W  = (L + 1) / 2;    // root bits
  localparam int unsigned RW    = 2 * SQ_W;       // radicand width (even)
  localparam int unsigned CW    = $clog2(L + 2);

  localparam logic [CW-1:0] LAST    = CW'(L);
  localparam logic [CW-1:0] SQ_LAST = CW'(SQ_W);
  localparam logic [DW-1:0] RCP_NUM = {{(DW-1){1'b0}}, 1'b1} << (2 * FRAC);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] d_q;
  logic [DW-1:0]    qd_q;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q;
  logic [RW-1:0]    rad_q;
  logic [SQ_W:0]    srem_q;
  logic [SQ_W-1:0]  root_q;
  logic [CW-1:0]    cnt_q;

  logic accept, finish;

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = CALC;
      CALC:    if (cnt_q == LAST)        state_d = DONE;
      DONE:    if (out_ready)            state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
`ifdef SFU_FLUSH_EN
    if (flush && (state_q != IDLE)) state_d = IDLE;
`endif
  end

  assign accept = (state_q == IDLE) && in_valid && in_ready;
  assign finish = (state_q == CALC) && (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // restoring division step
  logic [WIDTH:0]   dtmp;
  logic             dge;
  logic [WIDTH-1:0] dsub;

  always_comb begin
    dtmp = {rem_q, qd_q[DW-1]};
    dge  = (dtmp >= {1'b0, d_q});
    // result is < d_q whenever dge, so modulo-2^WIDTH subtraction is exact
    dsub = dtmp[WIDTH-1:0] - d_q;
  end

  // digit-by-digit square root step
  logic [SQ_W+2:0] sa, sb;
  logic            sge;
  logic [SQ_W:0]   ssub;

  always_comb begin
    sa   = {srem_q, rad_q[RW-1:RW-2]};
    sb   = {1'b0, root_q, 2'b01};
    sge  = (sa >= sb);
    // remainder never exceeds 2*root, so it fits SQ_W+1 bits
    ssub = sa[SQ_W:0] - sb[SQ_W:0];
  end

  logic [RW-1:0] rad_init;
  always_comb begin
    rad_init           = '0;
    rad_init[DW-1:0]   = {in_data, {FRAC{1'b0}}};
  end

  logic [WIDTH-1:0] root_ext;
  always_comb begin
    root_ext             = '0;
    root_ext[SQ_W-1:0]   = root_q;
  end

  // final result selection
  logic [WIDTH-1:0] res_data;
  logic [2:0]       res_flags;

  always_comb begin
    res_data  = '0;
    res_flags = '0;
    case (op_q)
      2'b00: begin
        if (d_q == '0) begin
          res_data  = '1;
          res_flags = 3'b001;
        end else if (|qd_q[DW-1:WIDTH]) begin
          res_data  = '1;
          res_flags = 3'b010;
        end else begin
          res_data  = qd_q[WIDTH-1:0];
        end
      end
      2'b01:   res_data  = root_ext;
      default: res_flags = 3'b100;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      tag_q     <= '0;
      d_q       <= '0;
      qd_q      <= '0;
      rem_q     <= '0;
      rad_q     <= '0;
      srem_q    <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else begin
      if (accept) begin
        op_q   <= in_op;
        tag_q  <= in_tag;
        d_q    <= in_data;
        qd_q   <= RCP_NUM;
        rem_q  <= '0;
        rad_q  <= rad_init;
        srem_q <= '0;
        root_q <= '0;
        cnt_q  <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CW'(1);
        // the division needs all L steps; the root is complete after
        // SQ_W steps and simply idles for the rest of the fixed latency
        if (cnt_q != LAST) begin
          qd_q  <= {qd_q[DW-2:0], dge};
          rem_q <= dge ? dsub : dtmp[WIDTH-1:0];
        end
        if (cnt_q < SQ_LAST) begin
          rad_q  <= {rad_q[RW-3:0], 2'b00};
          srem_q <= sge ? ssub : sa[SQ_W:0];
          root_q <= {root_q[SQ_W-2:0], sge};
        end
      end
      if (finish) begin
        out_data  <= res_data;
        out_flags <= res_flags;
        out_tag   <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_sfu_iter.sv
module tb_sfu_iter;

  localparam int W   = 32;
  localparam int F   = 16;
  localparam int T   = 4;
  localparam int LAT = W + F + 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_data;
  logic [T-1:0] in_tag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [T-1:0] out_tag;
  logic [2:0]   out_flags;
`ifdef SFU_FLUSH_EN
  logic         flush;
`endif

  sfu_iter #(.WIDTH(W), .FRAC(F), .TAG_W(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_flags (out_flags)
`ifdef SFU_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [T-1:0] tag;
    logic [W-1:0] data;
    logic [2:0]   flags;
    int           acc;
  } exp_t;

  exp_t sb[$];

  // literal expectation override for directed requests
  logic         lit_en;
  logic [W-1:0] lit_data;
  logic [2:0]   lit_flags;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", name, $time);
  endtask

  // reference behaviour from plain arithmetic
  function automatic void model(input logic [1:0] op, input logic [W-1:0] d,
                                output logic [W-1:0] r, output logic [2:0] f);
    longint unsigned q, x, s;
    r = '0;
    f = '0;
    case (op)
      2'b00: begin
        if (d == 0) begin
          r = '1;
          f = 3'b001;
        end else begin
          q = (64'd1 << (2 * F)) / longint'(d);
          if (q >= (64'd1 << W)) begin
            r = '1;
            f = 3'b010;
          end else begin
            r = q[W-1:0];
          end
        end
      end
      2'b01: begin
        x = longint'(d) << F;
        s = 64'($rtoi($sqrt(real'(x))));
        while (s * s > x) s = s - 1;
        while ((s + 1) * (s + 1) <= x) s = s + 1;
        r = s[W-1:0];
      end
      default: f = 3'b100;
    endcase
  endfunction

  // compare process: every cycle with valid output, and every accept
  bit prev_ov = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    logic [W-1:0] md;
    logic [2:0]   mf;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = sb[0];
          if (!prev_ov) chk("latency", 64'(cyc), 64'(e.acc + LAT));
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("out_flags", 64'(out_flags), 64'(e.flags));
          chk("in_ready_busy", 64'(in_ready), 64'd0);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (lit_en) begin
          md = lit_data;
          mf = lit_flags;
        end else begin
          model(in_op, in_data, md, mf);
        end
        e.tag   = in_tag;
        e.data  = md;
        e.flags = mf;
        e.acc   = cyc + 1;
        sb.push_back(e);
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic [T-1:0] tag);
    in_op    = op;
    in_data  = d;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lit_en   = 1'b0;
        // scramble inputs after accept; the unit must have latched them
        in_op    = 2'($urandom);
        in_data  = $urandom;
        in_tag   = T'($urandom);
        return;
      end
    end
    in_valid = 1'b0;
    lit_en   = 1'b0;
    timeout("accept");
  endtask

  task automatic wait_done(input bit bp);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) begin
        out_ready = 1'b1;
        return;
      end
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    out_ready = 1'b1;
    timeout("result");
  endtask

  task automatic wait_out_valid();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) return;
    end
    timeout("out_valid");
  endtask

  // directed transaction with a hand-computed expectation that also pins the model
  task automatic drv(input logic [1:0] op, input logic [W-1:0] d, input logic [T-1:0] tag,
                     input logic [W-1:0] ed, input logic [2:0] ef);
    logic [W-1:0] md;
    logic [2:0]   mf;
    model(op, d, md, mf);
    chk("model_pin_data", 64'(md), 64'(ed));
    chk("model_pin_flags", 64'(mf), 64'(ef));
    lit_en    = 1'b1;
    lit_data  = ed;
    lit_flags = ef;
    out_ready = 1'b1;
    send(op, d, tag);
    wait_done(1'b0);
  endtask

  initial begin : watchdog
    #2000000;
    timeout("global_watchdog");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    logic [1:0]   op;
    logic [W-1:0] d;
    int           sel;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    lit_en    = 1'b0;
    lit_data  = '0;
    lit_flags = '0;
`ifdef SFU_FLUSH_EN
    flush     = 1'b0;
`endif
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    #20;
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // directed: reciprocal
    drv(2'b00, 32'h0002_0000, 4'h3, 32'h0000_8000, 3'b000);
    drv(2'b00, 32'h0003_0000, 4'h1, 32'h0000_5555, 3'b000);
    drv(2'b00, 32'h0000_0001, 4'h2, 32'hFFFF_FFFF, 3'b010);
    drv(2'b00, 32'h0000_0000, 4'h4, 32'hFFFF_FFFF, 3'b001);
    drv(2'b00, 32'h0000_0002, 4'h5, 32'h8000_0000, 3'b000);
    drv(2'b00, 32'hFFFF_FFFF, 4'h6, 32'h0000_0001, 3'b000);
    // directed: square root and illegal ops
    drv(2'b01, 32'h0004_0000, 4'h7, 32'h0002_0000, 3'b000);
    drv(2'b01, 32'h0002_0000, 4'h8, 32'h0001_6A09, 3'b000);
    drv(2'b01, 32'h0000_0000, 4'h9, 32'h0000_0000, 3'b000);
    drv(2'b10, 32'h1234_5678, 4'hA, 32'h0000_0000, 3'b100);
    drv(2'b11, 32'h0001_0000, 4'hB, 32'h0000_0000, 3'b100);

    // back-pressure with a second request held on in_valid
    out_ready = 1'b0;
    lit_en    = 1'b1;
    lit_data  = 32'h0000_3333;
    lit_flags = 3'b000;
    send(2'b00, 32'h0005_0000, 4'hC);
    wait_out_valid();
    lit_en    = 1'b1;
    lit_data  = 32'h0003_0000;
    lit_flags = 3'b000;
    in_op     = 2'b01;
    in_data   = 32'h0009_0000;
    in_tag    = 4'h5;
    in_valid  = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after_hs", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_en   = 1'b0;
    chk("bp_second_accepted", 64'(in_ready), 64'd0);
    wait_done(1'b0);

    // reset in the middle of a computation
    send(2'b00, 32'h0007_0000, 4'hD);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_tag", 64'(out_tag), 64'd0);
    chk("midrst_out_flags", 64'(out_flags), 64'd0);
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk("midrst_in_ready_pre", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("midrst_in_ready_post", 64'(in_ready), 64'd1);
    chk("midrst_no_stale_valid", 64'(out_valid), 64'd0);
    drv(2'b00, 32'h0002_0000, 4'hE, 32'h0000_8000, 3'b000);

`ifdef SFU_FLUSH_EN
    // abort during computation
    send(2'b01, 32'h0010_0000, 4'h6);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    chk("flush_calc_in_ready", 64'(in_ready), 64'd1);
    chk("flush_calc_out_valid", 64'(out_valid), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    // abort while a result is waiting
    out_ready = 1'b0;
    send(2'b00, 32'h0004_0000, 4'h7);
    wait_out_valid();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    sb.delete();
    chk("flush_done_out_valid", 64'(out_valid), 64'd0);
    chk("flush_done_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    // flush together with a request in IDLE: the request wins
    flush = 1'b1;
    send(2'b01, 32'h0019_0000, 4'h2);
    flush = 1'b0;
    wait_done(1'b0);
`endif

    // randomized traffic with random back-pressure
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 2'b00 : (sel < 8) ? 2'b01 : 2'($urandom_range(2, 3));
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 255));
        2:       d = $urandom & 32'h000F_FFFF;
        default: d = $urandom | 32'hFFFF_0000;
      endcase
      lit_en = 1'b0;
      send(op, d, T'($urandom));
      wait_done(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
